// File: rtl/steer_en_sm.sv
// -----------------------------------------------------------------------------
// steer_en_sm
//   Rider-presence and steering-enable sequencer for the balance datapath.
//   Captures left/right load-cell conversions and decides whether a rider is
//   on board. Once a rider has stayed balanced for a fixed settle time, the
//   block enables steering. The balance controller uses rider_off to clear its
//   integrator and en_steer to gate steering.
//
// Parameters:
//   fast_sim      1: settle time is 2^15 clocks; 0: 2^26 clocks (~1.34 s @ 50 MHz)
//   MIN_RIDER_WT  nominal rider-present threshold on the load sum
//   WT_HYSTERESIS half-width of the presence hysteresis band
//
// Ports:
//   clk        in   50 MHz system clock
//   rst_n      in   asynchronous active-low reset
//   pwr_up     in   Segway powered; low forces IDLE
//   ld_vld     in   single-cycle strobe: lft_ld/rght_ld hold a fresh conversion
//   lft_ld     in   [11:0] left load cell, unsigned
//   rght_ld    in   [11:0] right load cell, unsigned
//   en_steer   out  steering enabled (decoded from state register)
//   rider_off  out  no rider present (decoded from state register)
//   sm_state   out  [1:0] current state: 00 IDLE, 01 WAIT, 10 STEER_EN
// -----------------------------------------------------------------------------
module steer_en_sm #(
    parameter bit          fast_sim      = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_up,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic [1:0]  sm_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT     = 2'b01,
        S_STEER_EN = 2'b10
    } state_e;

    // Presence thresholds, widened to the 13-bit sum width.
    localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

    state_e      state_q, state_d;
    logic [11:0] lft_q, rght_q;
    logic [25:0] tmr_q, tmr_d;

    // -------------------------------------------------------------------------
    // Load capture: all decisions use the registered copies only.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q  <= 12'h000;
            rght_q <= 12'h000;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    // -------------------------------------------------------------------------
    // Load arithmetic (all comparisons 13-bit unsigned)
    // -------------------------------------------------------------------------
    logic [12:0] sum;
    logic [12:0] diff;
    logic [12:0] abs_diff;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        rider_on;
    logic        rider_gone;
    logic        tmr_full;

    assign sum  = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff = {1'b0, lft_q} - {1'b0, rght_q};
    // Magnitude of a 13-bit two's-complement difference of 12-bit operands
    // always fits in 12 bits, so abs_diff[12] is zero.
    assign abs_diff = diff[12] ? (13'd0 - diff) : diff;

    assign diff_gt_1_4   = abs_diff > {2'b00, sum[12:2]};
    assign diff_gt_15_16 = abs_diff > (sum - {4'b0000, sum[12:4]});

    assign rider_on   = sum > ON_THR;
    assign rider_gone = sum < OFF_THR;

    assign tmr_full = fast_sim ? (&tmr_q[14:0]) : (&tmr_q);

    // -------------------------------------------------------------------------
    // State and settle-timer registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= 26'd0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / timer logic. Priority: pwr_up, then presence, then balance.
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;

        if (!pwr_up) begin
            state_d = S_IDLE;
            tmr_d   = 26'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rider_on) begin
                        state_d = S_WAIT;
                        tmr_d   = 26'd0;
                    end
                end

                S_WAIT: begin
                    if (rider_gone) begin
                        state_d = S_IDLE;
                        tmr_d   = 26'd0;
                    end else if (diff_gt_1_4) begin
                        tmr_d = 26'd0;
                    end else if (tmr_full) begin
                        // Timer holds at full; it never wraps.
                        state_d = S_STEER_EN;
                    end else begin
                        tmr_d = tmr_q + 26'd1;
                    end
                end

                S_STEER_EN: begin
                    if (rider_gone) begin
                        state_d = S_IDLE;
                        tmr_d   = 26'd0;
                    end else if (diff_gt_15_16) begin
                        state_d = S_WAIT;
                        tmr_d   = 26'd0;
                    end
                end

                // Unused encoding 2'b11 recovers to IDLE on the next edge.
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = 26'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decode the state register only: no input-to-output path.
    // -------------------------------------------------------------------------
    assign en_steer  = (state_q == S_STEER_EN);
    assign rider_off = (state_q == S_IDLE);
    assign sm_state  = state_q;

endmodule
